trace_op_dispatcher: RTL

TRACE_OP_DISPATCHER -- requirements
Module: trace_op_dispatcher

---
 rtl/trace_pkg.sv | 62 ++++++
 rtl/trace_op_fifo.sv | 74 +++++++
 rtl/trace_op_dispatcher.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types for the trace-op dispatcher: opcodes, snoop results, FSM states
// and the routing/snoop-result decode helpers.
package trace_pkg;

    typedef enum logic [3:0] {
        OP_L1_RD    = 4'd0,
        OP_L1_WR    = 4'd1,
        OP_L1_FLUSH = 4'd2,
        OP_SNP_RD   = 4'd3,
        OP_SNP_RDX  = 4'd4,
        OP_SNP_UPGR = 4'd5,
        OP_SNP_INV  = 4'd6,
        OP_RSVD     = 4'd7,
        OP_CLEAR    = 4'd8,
        OP_PRINT    = 4'd9
    } trace_op_e;

    typedef enum logic [1:0] {
        SNP_HIT   = 2'b00,
        SNP_HITM  = 2'b01,
        SNP_NOHIT = 2'b10
    } snp_result_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRIVE_L1  = 2'd1,
        ST_DRIVE_SNP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RT_L1      = 3'd0,
        RT_SNP     = 3'd1,
        RT_CLEAR   = 3'd2,
        RT_PRINT   = 3'd3,
        RT_ILLEGAL = 3'd4
    } route_e;

    // Destination of a raw 4-bit opcode; anything outside 0-6, 8, 9 is illegal.
    function automatic route_e route_of(input logic [3:0] op);
        route_e rt;
        case (op)
            OP_L1_RD, OP_L1_WR, OP_L1_FLUSH:             rt = RT_L1;
            OP_SNP_RD, OP_SNP_RDX, OP_SNP_UPGR, OP_SNP_INV: rt = RT_SNP;
            OP_CLEAR:                                     rt = RT_CLEAR;
            OP_PRINT:                                     rt = RT_PRINT;
            default:                                      rt = RT_ILLEGAL;
        endcase
        return rt;
    endfunction

    // Snoop outcome derived from the two low address bits.
    function automatic snp_result_e snoop_result_of(input logic [1:0] lsb);
        snp_result_e res;
        case (lsb)
            2'b00:   res = SNP_HIT;
            2'b01:   res = SNP_HITM;
            default: res = SNP_NOHIT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trace_op_fifo.sv
// Trace-op input queue: DEPTH entries (power of 2) of WIDTH bits, head visible
// combinationally; push_ready is a flop that mirrors (count < DEPTH).
module trace_op_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   push_ready,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    // Pointer/occupancy update; ready is based on the registered count only.
    always_comb begin
        do_push  = push && ready_q;
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < CNT_W'(DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign push_ready = ready_q;

endmodule

// File: rtl/trace_op_dispatcher.sv
// Trace-op dispatcher: queues trace ops and routes them in order to the L1
// channel, the snoop channel, or the clear/print control pulses.
// Optional build macro TRACE_OP_DISPATCHER_STATS_EN enables the dispatch
// counters on stat_l1/stat_snp; without it both ports are tied to 0.
module trace_op_dispatcher
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SNOOP_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   l1_valid,
    input  logic                   l1_ready,
    output logic [3:0]             l1_op,
    output logic [ADDR_W-1:0]      l1_addr,
    output logic                   snp_valid,
    input  logic                   snp_ready,
    output logic [3:0]             snp_op,
    output logic [ADDR_W-1:0]      snp_addr,
    output logic [1:0]             snp_result,
    output logic                   snp_result_valid,
    output logic                   ctl_clear,
    output logic                   ctl_print,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_illegal,
    output logic [31:0]            stat_l1,
    output logic [31:0]            stat_snp
);

    localparam int unsigned PAY_W = 4 + ADDR_W;

    logic [PAY_W-1:0]  fifo_head;
    logic              fifo_pop;
    logic [3:0]        head_op;
    logic [ADDR_W-1:0] head_addr;

    state_e            state_q, state_d;
    logic              l1_valid_q, l1_valid_d;
    logic [3:0]        l1_op_q, l1_op_d;
    logic [ADDR_W-1:0] l1_addr_q, l1_addr_d;
    logic              snp_valid_q, snp_valid_d;
    logic [3:0]        snp_op_q, snp_op_d;
    logic [ADDR_W-1:0] snp_addr_q, snp_addr_d;
    logic              ctl_clear_q, ctl_clear_d;
    logic              ctl_print_q, ctl_print_d;
    logic              err_illegal_q, err_illegal_d;
    logic              l1_hs, snp_hs;

    logic [SNOOP_LAT-1:0] pipe_vld_q, pipe_vld_d;
    snp_result_e          pipe_res_q [SNOOP_LAT];
    snp_result_e          pipe_res_d [SNOOP_LAT];

    trace_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (in_valid),
        .push_data  ({in_op, in_addr}),
        .push_ready (in_ready),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (count)
    );

    assign head_op   = fifo_head[ADDR_W +: 4];
    assign head_addr = fifo_head[ADDR_W-1:0];
    assign l1_hs     = l1_valid_q && l1_ready;
    assign snp_hs    = snp_valid_q && snp_ready;

    // Next-state and output-register logic: pop in IDLE, hold payload until handshake.
    always_comb begin
        state_d       = state_q;
        l1_valid_d    = l1_valid_q;
        l1_op_d       = l1_op_q;
        l1_addr_d     = l1_addr_q;
        snp_valid_d   = snp_valid_q;
        snp_op_d      = snp_op_q;
        snp_addr_d    = snp_addr_q;
        ctl_clear_d   = 1'b0;
        ctl_print_d   = 1'b0;
        err_illegal_d = err_illegal_q;
        fifo_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    fifo_pop = 1'b1;
                    case (route_of(head_op))
                        RT_L1: begin
                            l1_valid_d = 1'b1;
                            l1_op_d    = head_op;
                            l1_addr_d  = head_addr;
                            state_d    = ST_DRIVE_L1;
                        end
                        RT_SNP: begin
                            snp_valid_d = 1'b1;
                            snp_op_d    = head_op;
                            snp_addr_d  = head_addr;
                            state_d     = ST_DRIVE_SNP;
                        end
                        RT_CLEAR: ctl_clear_d   = 1'b1;
                        RT_PRINT: ctl_print_d   = 1'b1;
                        default:  err_illegal_d = 1'b1;
                    endcase
                end
            end
            ST_DRIVE_L1: begin
                if (l1_hs) begin
                    l1_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DRIVE_SNP: begin
                if (snp_hs) begin
                    snp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and channel output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            l1_valid_q    <= 1'b0;
            l1_op_q       <= '0;
            l1_addr_q     <= '0;
            snp_valid_q   <= 1'b0;
            snp_op_q      <= '0;
            snp_addr_q    <= '0;
            ctl_clear_q   <= 1'b0;
            ctl_print_q   <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            l1_valid_q    <= l1_valid_d;
            l1_op_q       <= l1_op_d;
            l1_addr_q     <= l1_addr_d;
            snp_valid_q   <= snp_valid_d;
            snp_op_q      <= snp_op_d;
            snp_addr_q    <= snp_addr_d;
            ctl_clear_q   <= ctl_clear_d;
            ctl_print_q   <= ctl_print_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    // Snoop result shift pipeline; one stage per cycle of latency so results never collide.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_vld_d[0] = snp_hs;
        pipe_res_d[0] = snp_hs ? snoop_result_of(snp_addr_q[1:0]) : SNP_NOHIT;
        for (int i = 1; i < int'(SNOOP_LAT); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_res_d[i] = pipe_res_q[i-1];
        end
    end

    // Snoop pipeline registers; reset flushes any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(SNOOP_LAT); i++) begin
                pipe_res_q[i] <= SNP_NOHIT;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < int'(SNOOP_LAT); i++) begin
                pipe_res_q[i] <= pipe_res_d[i];
            end
        end
    end

`ifdef TRACE_OP_DISPATCHER_STATS_EN
    logic [31:0] stat_l1_q, stat_l1_d;
    logic [31:0] stat_snp_q, stat_snp_d;

    // Free-running handshake counters, wrapping at 2^32.
    always_comb begin
        stat_l1_d  = stat_l1_q + (l1_hs ? 32'd1 : 32'd0);
        stat_snp_d = stat_snp_q + (snp_hs ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_l1_q  <= '0;
            stat_snp_q <= '0;
        end else begin
            stat_l1_q  <= stat_l1_d;
            stat_snp_q <= stat_snp_d;
        end
    end

    assign stat_l1  = stat_l1_q;
    assign stat_snp = stat_snp_q;
`else
    assign stat_l1  = '0;
    assign stat_snp = '0;
`endif

    assign l1_valid         = l1_valid_q;
    assign l1_op            = l1_op_q;
    assign l1_addr          = l1_addr_q;
    assign snp_valid        = snp_valid_q;
    assign snp_op           = snp_op_q;
    assign snp_addr         = snp_addr_q;
    assign snp_result       = pipe_res_q[SNOOP_LAT-1];
    assign snp_result_valid = pipe_vld_q[SNOOP_LAT-1];
    assign ctl_clear        = ctl_clear_q;
    assign ctl_print        = ctl_print_q;
    assign err_illegal      = err_illegal_q;

endmodule
